// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit: fixed-latency multiplier plus a
// restoring radix-2 divider, one operation in flight, valid/ready handshake.
module ex_muldiv_unit #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2,
   parameter int TAG_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

   state_t state_q, state_d;

   logic [1:0]        op_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
   logic              neg_q_q, neg_r_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] res_q;
   logic [TAG_W-1:0]  otag_q;

   logic              accept, in_is_div, in_signed, in_is_mod;
   logic              div_zero, div_ovf, div_special;
   logic [DATA_W-1:0] src1_mag, src2_mag;

   assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
   assign accept      = in_valid && in_ready && !flush;
   assign in_is_div   = in_op[2];
   assign in_signed   = !in_op[0];
   assign in_is_mod   = in_op[1];
   assign div_zero    = (in_src2 == '0);
   assign div_ovf     = in_signed && (in_src1 == MIN_NEG) && (in_src2 == '1);
   assign div_special = in_is_div && (div_zero || div_ovf);
   assign src1_mag    = (in_signed && in_src1[DATA_W-1]) ? -in_src1 : in_src1;
   assign src2_mag    = (in_signed && in_src2[DATA_W-1]) ? -in_src2 : in_src2;

   // one multiplier serves all three flavours: MULHU zero-extends, others sign-extend
   logic                ext_a, ext_b;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   mul_res;

   assign ext_a   = (op_q != 2'b10) && a_q[DATA_W-1];
   assign ext_b   = (op_q != 2'b10) && b_q[DATA_W-1];
   assign prod    = {{DATA_W{ext_a}}, a_q} * {{DATA_W{ext_b}}, b_q};
   assign mul_res = (op_q == 2'b01 || op_q == 2'b10) ? prod[2*DATA_W-1:DATA_W]
                                                     : prod[DATA_W-1:0];

   logic [DATA_W:0]   rem_sh, diff;
   logic [DATA_W-1:0] q_fix, r_fix, div_res;

   assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign q_fix   = neg_q_q ? -quo_q : quo_q;
   assign r_fix   = neg_r_q ? -rem_q : rem_q;
   assign div_res = op_q[1] ? r_fix : q_fix;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept)                               state_d = in_is_div ? ST_DIV : ST_MUL;
            else if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
         end
         ST_MUL, ST_DIV: if (cnt_q == '0) state_d = ST_DONE;
         default:        state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= '0;
         tag_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         otag_q  <= '0;
      end else if (accept) begin
         op_q  <= in_op[1:0];
         tag_q <= in_tag;
         a_q   <= in_src1;
         b_q   <= in_src2;
         dvs_q <= src2_mag;
         if (div_special) begin
            // preload quotient/remainder so the single fixup cycle yields the fixed answer
            quo_q   <= div_zero ? '1 : MIN_NEG;
            rem_q   <= div_zero ? in_src1 : '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            quo_q   <= src1_mag;
            rem_q   <= '0;
            neg_q_q <= in_signed && (in_src1[DATA_W-1] ^ in_src2[DATA_W-1]);
            neg_r_q <= in_signed && in_src1[DATA_W-1];
            cnt_q   <= in_is_div ? CNT_W'(DATA_W) : CNT_W'(MUL_LAT - 1);
         end
      end else if (!flush) begin
         case (state_q)
            ST_MUL: begin
               if (cnt_q == '0) begin
                  res_q  <= mul_res;
                  otag_q <= tag_q;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_DIV: begin
               if (cnt_q != '0) begin
                  rem_q <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
                  quo_q <= {quo_q[DATA_W-2:0], !diff[DATA_W]};
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  res_q  <= div_res;
                  otag_q <= tag_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign out_result = res_q;
   assign out_tag    = otag_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic reference model with per-cycle compare
// on a 32-bit unit, directed corner cases, and a 16-bit / MUL_LAT=1 instance.
module tb_ex_muldiv_unit;

   localparam int W  = 32;
   localparam int ML = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  in_op;
   logic [31:0] in_src1, in_src2, out_result;
   logic [4:0]  in_tag, out_tag;

   logic        v16, rdy16, ov16, or16, busy16, flush16;
   logic [2:0]  op16;
   logic [15:0] a16, b16, res16;
   logic [4:0]  tag16, otag16;

   ex_muldiv_unit #(.DATA_W(W), .MUL_LAT(ML), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .busy(busy));

   ex_muldiv_unit #(.DATA_W(16), .MUL_LAT(1), .TAG_W(5)) dut16 (
      .clk(clk), .rst(rst), .flush(flush16), .in_valid(v16), .in_ready(rdy16),
      .in_op(op16), .in_src1(a16), .in_src2(b16), .in_tag(tag16),
      .out_valid(ov16), .out_ready(or16), .out_result(res16),
      .out_tag(otag16), .busy(busy16));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_fn(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
      longint unsigned mask, ua, ub, r, q, rm;
      longint          sa, sb;
      mask = (64'd1 << w) - 64'd1;
      ua = a & mask;
      ub = b & mask;
      sa = ua[w-1] ? longint'(ua | ~mask) : longint'(ua);
      sb = ub[w-1] ? longint'(ub | ~mask) : longint'(ub);
      if (!op[2]) begin
         case (op[1:0])
            2'b01:   r = 64'((sa * sb) >>> w);
            2'b10:   r = (ua * ub) >> w;
            default: r = 64'(sa * sb);
         endcase
      end else begin
         if (ub == 0) begin
            q = mask; rm = ua;
         end else if (!op[0] && ua == (64'd1 << (w - 1)) && ub == mask) begin
            q = 64'd1 << (w - 1); rm = 0;
         end else if (!op[0]) begin
            q = 64'(sa / sb); rm = 64'(sa % sb);
         end else begin
            q = ua / ub; rm = ua % ub;
         end
         r = op[1] ? rm : q;
      end
      return r & mask;
   endfunction

   function automatic int lat_fn(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input int w, input int ml);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      if (!op[2]) return ml;
      if ((b & mask) == 0) return 1;
      if (!op[0] && (a & mask) == (64'd1 << (w - 1)) && (b & mask) == mask) return 1;
      return w + 1;
   endfunction

   // reference model of the 32-bit unit: at most one pending result, due at a cycle number
   bit          pend;
   int          cyc, due;
   logic [31:0] m_res;
   logic [4:0]  m_tag;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= 1'b0;
         cyc  <= 0;
      end else begin
         cyc <= cyc + 1;
         if (flush) pend <= 1'b0;
         else if (in_valid && (!pend || (cyc >= due && out_ready))) begin
            pend  <= 1'b1;
            due   <= cyc + 1 + lat_fn(in_op, 64'(in_src1), 64'(in_src2), W, ML);
            m_res <= 32'(exp_fn(in_op, 64'(in_src1), 64'(in_src2), W));
            m_tag <= in_tag;
         end else if (pend && cyc >= due && out_ready) pend <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_busy", 64'(busy), 64'(0));
         chk("rst_in_ready", 64'(in_ready), 64'(1));
         chk("rst_out_result", 64'(out_result), 64'(0));
         chk("rst_out_tag", 64'(out_tag), 64'(0));
      end else begin
         chk("out_valid", 64'(out_valid), 64'(pend && cyc >= due));
         chk("busy", 64'(busy), 64'(pend));
         chk("in_ready", 64'(in_ready), 64'(!pend || (cyc >= due && out_ready)));
         if (pend && cyc >= due) begin
            chk("out_result", 64'(out_result), 64'(m_res));
            chk("out_tag", 64'(out_tag), 64'(m_tag));
         end
      end
   end

   int acc_cyc;

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      bit acc = 1'b0;
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk); acc = in_ready && !flush;
         @(posedge clk); #1;
      end
      chk("accept_timeout", 64'(acc), 64'(1));
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_op = 3'($urandom); in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'($urandom);
   endtask

   task automatic wait_res(input string name, input int lat, input logic [31:0] res,
                           input logic [4:0] tag);
      bit          seen = 1'b0;
      int          got_lat = -1;
      logic [31:0] got_res = '0;
      logic [4:0]  got_tag = '0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1; got_lat = cyc - acc_cyc; got_res = out_result; got_tag = out_tag;
         end
         @(posedge clk); #1;
      end
      chk({name, "_lat"}, 64'(got_lat), 64'(lat));
      chk({name, "_res"}, 64'(got_res), 64'(res));
      chk({name, "_tag"}, 64'(got_tag), 64'(tag));
   endtask

   task automatic run16(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] tag, input int lat,
                        input logic [15:0] res);
      bit          acc = 1'b0;
      int          got_lat = -1;
      logic [15:0] got_res = '0;
      logic [4:0]  got_tag = '0;
      v16 = 1'b1; op16 = op; a16 = a; b16 = b; tag16 = tag;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk); acc = rdy16;
         @(posedge clk); #1;
      end
      chk({name, "_accept"}, 64'(acc), 64'(1));
      v16 = 1'b0; op16 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      for (int t = 0; t < 100 && got_lat < 0; t++) begin
         @(negedge clk);
         if (ov16) begin
            got_lat = t; got_res = res16; got_tag = otag16;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      chk({name, "_lat"}, 64'(got_lat), 64'(lat));
      chk({name, "_res"}, 64'(got_res), 64'(res));
      chk({name, "_tag"}, 64'(got_tag), 64'(tag));
   endtask

   function automatic logic [31:0] rnd_a();
      case ($urandom_range(0, 7))
         0:       return 32'h8000_0000;
         1:       return 32'($urandom_range(0, 20));
         2:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rnd_b();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(1, 9));
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          c0, nvalid;
      logic [2:0]  op;
      logic [15:0] ra, rb;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
      in_tag = '0; out_ready = 1'b1;
      flush16 = 1'b0; v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; tag16 = '0; or16 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd7);
      chk("first_edge_accept", 64'(acc_cyc), 64'(1));
      wait_res("mulh", 2, 32'hFFFF_FFFF, 5'd7);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1);
      wait_res("div_neg", 33, 32'hFFFF_FFFD, 5'd1);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2);
      wait_res("mod_neg", 33, 32'hFFFF_FFFF, 5'd2);
      issue(3'b101, 32'd100, 32'd0, 5'd3);
      wait_res("divu_zero", 1, 32'hFFFF_FFFF, 5'd3);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      wait_res("div_ovf", 1, 32'h8000_0000, 5'd4);
      issue(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd5);
      wait_res("mod_zero", 1, 32'hFFFF_FFFB, 5'd5);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
      wait_res("mulhu", 2, 32'hFFFF_FFFE, 5'd6);
      issue(3'b011, 32'd7, 32'hFFFF_FFFD, 5'd8);
      wait_res("mul_rsvd", 2, 32'hFFFF_FFEB, 5'd8);

      // flush in the 10th cycle of a divide, with a competing request
      issue(3'b100, 32'd1000, 32'd3, 5'd10);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1; in_valid = 1'b1; in_op = 3'b000;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_busy", 64'(busy), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      nvalid = 0;
      repeat (40) begin @(negedge clk); if (out_valid) nvalid++; end
      chk("flush_no_result", 64'(nvalid), 64'(0));
      @(posedge clk); #1;

      // backpressure, then retire and accept on the same edge
      out_ready = 1'b0;
      issue(3'b000, 32'd5, 32'd6, 5'd3);
      wait_res("bp_first", 2, 32'd30, 5'd3);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(out_valid), 64'(1));
         chk("bp_hold_res", 64'(out_result), 64'(30));
         chk("bp_hold_tag", 64'(out_tag), 64'(3));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      c0 = cyc;
      issue(3'b000, 32'd3, 32'd4, 5'd9);
      chk("bp_same_edge", 64'(acc_cyc), 64'(c0 + 1));
      wait_res("bp_second", 2, 32'd12, 5'd9);

      // random traffic checked every cycle by the model
      for (int i = 0; i < 2500; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_op     = 3'($urandom_range(0, 7));
         in_src1   = rnd_a();
         in_src2   = rnd_b();
         in_tag    = 5'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (40) begin @(posedge clk); #1; end

      // asynchronous reset in the middle of a divide
      issue(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd2);
      repeat (5) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_valid", 64'(out_valid), 64'(0));
      chk("arst_in_ready", 64'(in_ready), 64'(1));
      chk("arst_result", 64'(out_result), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      nvalid = 0;
      repeat (45) begin @(negedge clk); if (out_valid) nvalid++; end
      chk("arst_no_result", 64'(nvalid), 64'(0));
      @(posedge clk); #1;

      // 16-bit unit with single-cycle multiply
      run16("divu16", 3'b101, 16'd1000, 16'd7, 5'd11, 17, 16'd142);
      run16("mul16", 3'b000, 16'd3, 16'd4, 5'd12, 1, 16'd12);
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 7));
         ra = (i % 4 == 0) ? 16'h8000 : 16'($urandom);
         rb = (i % 5 == 0) ? 16'h0 : ((i % 4 == 0) ? 16'hFFFF : 16'($urandom));
         run16("rand16", op, ra, rb, 5'(i),
               lat_fn(op, 64'(ra), 64'(rb), 16, 1), 16'(exp_fn(op, 64'(ra), 64'(rb), 16)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
